// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regs
// Brief    : I2C target (responder) fronting an addressable 8-bit register file
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_regs #(
   parameter logic [6:0] ADDR       = 7'h1E,
   parameter int         NREG       = 16,
   parameter int         FILTER_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o,
   output logic       sda_t,
   input  logic       host_wr_en,
   input  logic [7:0] host_wr_addr,
   input  logic [7:0] host_wr_data,
   output logic       i2c_wr_valid,
   output logic [7:0] i2c_wr_addr,
   output logic [7:0] i2c_wr_data,
   output logic       busy,
   output logic       addressed
);
   localparam int PW = $clog2(NREG);
   localparam int CW = $clog2(FILTER_LEN + 1);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8,
      ST_IGNORE    = 4'd9
   } state_t;

   state_t          r_state, w_state_nxt;
   logic            r_phase, r_rw, r_sda_t, r_busy, r_addressed, r_wr_valid;
   logic [2:0]      r_bitcnt;
   logic [6:0]      r_shift;
   logic [PW-1:0]   r_ptr;
   logic [7:0]      r_wr_addr, r_wr_data;
   logic [7:0]      r_regs [NREG];

   logic [1:0]      w_raw, w_lvl, w_lvl_d;
   logic            w_scl_rise, w_scl_fall, w_start, w_stop, w_bit8, w_enter_rd;
   logic [7:0]      w_byte;

   // Index 0 is SCL, index 1 is SDA: synchronize, then hold off changes until stable.
   assign w_raw = {sda_i, scl_i};
   for (genvar gi = 0; gi < 2; gi++) begin : g_filt
      logic          r_s1, r_s2, r_lvl, r_lvl_d;
      logic [CW-1:0] r_cnt;
      always_ff @(posedge clk) begin
         if (rst) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_lvl   <= 1'b1;
            r_lvl_d <= 1'b1;
            r_cnt   <= '0;
         end else begin
            r_s1    <= w_raw[gi];
            r_s2    <= r_s1;
            r_lvl_d <= r_lvl;
            if (r_s2 == r_lvl) begin
               r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
               r_lvl <= r_s2;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
      assign w_lvl[gi]   = r_lvl;
      assign w_lvl_d[gi] = r_lvl_d;
   end

   if (PW < 8) begin : g_addr_hi
      logic w_unused_hi;
      assign w_unused_hi = ^host_wr_addr[7:PW];
   end

   assign w_scl_rise = w_lvl[0] & ~w_lvl_d[0];
   assign w_scl_fall = ~w_lvl[0] & w_lvl_d[0];
   assign w_start    = w_lvl[0] & w_lvl_d[0] & ~w_lvl[1] & w_lvl_d[1];
   assign w_stop     = w_lvl[0] & w_lvl_d[0] & w_lvl[1] & ~w_lvl_d[1];
   assign w_byte     = {r_shift, w_lvl[1]};
   assign w_bit8     = w_scl_rise && (r_bitcnt == 3'd7);
   assign w_enter_rd = (w_state_nxt == ST_RDATA) && (r_state != ST_RDATA);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // ACK states use r_phase: 0 until the SCL fall after bit 8, 1 for the ACK bit itself.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ADDR:      if (w_bit8) w_state_nxt = (w_byte[7:1] == ADDR) ? ST_ADDR_ACK : ST_IGNORE;
         ST_ADDR_ACK:  if (w_scl_fall && r_phase) w_state_nxt = r_rw ? ST_RDATA : ST_PTR;
         ST_PTR:       if (w_bit8) w_state_nxt = ST_PTR_ACK;
         ST_PTR_ACK,
         ST_WDATA_ACK: if (w_scl_fall && r_phase) w_state_nxt = ST_WDATA;
         ST_WDATA:     if (w_bit8) w_state_nxt = ST_WDATA_ACK;
         ST_RDATA:     if (w_bit8) w_state_nxt = ST_RDATA_ACK;
         ST_RDATA_ACK: begin
            if (w_scl_rise && r_phase && w_lvl[1]) w_state_nxt = ST_IGNORE;
            else if (w_scl_fall && r_phase)        w_state_nxt = ST_RDATA;
         end
         default:      w_state_nxt = r_state;
      endcase
      if (w_stop)       w_state_nxt = ST_IDLE;
      else if (w_start) w_state_nxt = ST_ADDR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase     <= 1'b0;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_rw        <= 1'b0;
         r_ptr       <= '0;
         r_sda_t     <= 1'b1;
         r_busy      <= 1'b0;
         r_addressed <= 1'b0;
         r_wr_valid  <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         r_wr_valid <= 1'b0;
         if (host_wr_en) r_regs[host_wr_addr[PW-1:0]] <= host_wr_data;

         if (w_start || w_stop || (w_state_nxt != r_state)) begin
            r_phase  <= 1'b0;
            r_bitcnt <= '0;
         end else begin
            if (w_scl_fall) r_phase  <= 1'b1;
            if (w_scl_rise) r_bitcnt <= r_bitcnt + 1'b1;
         end

         if (w_start) begin
            r_busy      <= 1'b1;
            r_addressed <= 1'b0;
         end else if (w_stop) begin
            r_busy      <= 1'b0;
            r_addressed <= 1'b0;
         end else if (r_state == ST_ADDR && w_state_nxt == ST_ADDR_ACK) begin
            r_addressed <= 1'b1;
         end else if (w_state_nxt == ST_IGNORE) begin
            r_addressed <= 1'b0;
         end

         if (w_enter_rd)
            r_shift <= r_regs[r_ptr][6:0];
         else if (r_state == ST_RDATA && w_scl_fall)
            r_shift <= {r_shift[5:0], 1'b0};
         else if (w_scl_rise && (r_state == ST_ADDR || r_state == ST_PTR || r_state == ST_WDATA))
            r_shift <= w_byte[6:0];

         // Bus write placed after the host write so it wins on an index collision.
         if (w_bit8) begin
            case (r_state)
               ST_ADDR: r_rw  <= w_byte[0];
               ST_PTR:  r_ptr <= w_byte[PW-1:0];
               ST_WDATA: begin
                  r_regs[r_ptr] <= w_byte;
                  r_wr_valid    <= 1'b1;
                  r_wr_addr     <= 8'(r_ptr);
                  r_wr_data     <= w_byte;
                  r_ptr         <= r_ptr + 1'b1;
               end
               default: ;
            endcase
         end
         if (r_state == ST_RDATA_ACK && r_phase && w_scl_rise) r_ptr <= r_ptr + 1'b1;

         if (w_start || w_stop) begin
            r_sda_t <= 1'b1;
         end else if (w_enter_rd) begin
            r_sda_t <= r_regs[r_ptr][7];
         end else if (w_scl_fall) begin
            case (r_state)
               ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: r_sda_t <= r_phase;
               ST_RDATA: r_sda_t <= r_shift[6];
               default:  r_sda_t <= 1'b1;
            endcase
         end
      end
   end

   assign sda_o        = 1'b0;
   assign sda_t        = r_sda_t;
   assign busy         = r_busy;
   assign addressed    = r_addressed;
   assign i2c_wr_valid = r_wr_valid;
   assign i2c_wr_addr  = r_wr_addr;
   assign i2c_wr_data  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// Directed bench for i2c_target_regs: bit-banged I2C master plus hand-computed expectations.
module tb_i2c_target_regs;
   localparam int T  = 20;
   localparam int HT = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m_scl = 1'b1, m_sda = 1'b1;
   logic       sda_bus, sda_o, sda_t;
   logic       host_wr_en = 1'b0;
   logic [7:0] host_wr_addr = '0, host_wr_data = '0;
   logic       i2c_wr_valid, busy, addressed;
   logic [7:0] i2c_wr_addr, i2c_wr_data;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;
   int drive_cnt = 0;
   logic [7:0] log_addr [64];
   logic [7:0] log_data [64];

   assign sda_bus = m_sda & (sda_t ? 1'b1 : sda_o);

   i2c_target_regs #(.ADDR(7'h1E), .NREG(16), .FILTER_LEN(4)) dut (
      .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_bus),
      .sda_o(sda_o), .sda_t(sda_t),
      .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
      .i2c_wr_valid(i2c_wr_valid), .i2c_wr_addr(i2c_wr_addr), .i2c_wr_data(i2c_wr_data),
      .busy(busy), .addressed(addressed)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (i2c_wr_valid === 1'b1) begin
         if (wr_cnt < 64) begin
            log_addr[wr_cnt] = i2c_wr_addr;
            log_data[wr_cnt] = i2c_wr_data;
         end
         wr_cnt = wr_cnt + 1;
      end
      if (sda_t === 1'b0) drive_cnt = drive_cnt + 1;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: run did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic host_write(input logic [7:0] a, input logic [7:0] d);
      host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
      wait_clk(1);
      host_wr_en = 1'b0;
   endtask

   task automatic bus_start();
      wait_clk(HT); m_sda = 1'b1; wait_clk(HT); m_scl = 1'b1;
      wait_clk(T);  m_sda = 1'b0; wait_clk(T);  m_scl = 1'b0;
   endtask

   task automatic bus_stop();
      wait_clk(HT); m_sda = 1'b0; wait_clk(HT); m_scl = 1'b1;
      wait_clk(T);  m_sda = 1'b1; wait_clk(T);
   endtask

   task automatic bus_bit(input logic b, output logic r);
      wait_clk(HT); m_sda = b; wait_clk(HT); m_scl = 1'b1;
      wait_clk(HT); r = sda_bus; wait_clk(HT); m_scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
      bus_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, r);
         d[i] = r;
      end
      bus_bit(nack, r);
   endtask

   // Holds a host write from the SCL rise of bit 8 until the bus write pulse appears.
   task automatic send_byte_host(input logic [7:0] d, input logic [7:0] ha, input logic [7:0] hd,
                                 output logic ack);
      logic r;
      int   n;
      for (int i = 7; i >= 1; i--) bus_bit(d[i], r);
      wait_clk(HT); m_sda = d[0]; wait_clk(HT);
      host_wr_en = 1'b1; host_wr_addr = ha; host_wr_data = hd; m_scl = 1'b1;
      n = 0;
      while (i2c_wr_valid !== 1'b1 && n < 2 * T) begin
         wait_clk(1);
         n++;
      end
      host_wr_en = 1'b0;
      n_checks++;
      if (n >= 2 * T) begin n_fail++; $display("FAIL conflict_pulse: waited %0d cycles, required pulse within %0d", n, 2 * T); end
      wait_clk(HT); m_scl = 1'b0;
      bus_bit(1'b1, ack);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_clk(4);
      n_checks++; if (sda_t !== 1'b1)        begin n_fail++; $display("FAIL rst_sda_t: got %b want 1", sda_t); end
      n_checks++; if (sda_o !== 1'b0)        begin n_fail++; $display("FAIL rst_sda_o: got %b want 0", sda_o); end
      n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (addressed !== 1'b0)    begin n_fail++; $display("FAIL rst_addressed: got %b want 0", addressed); end
      n_checks++; if (i2c_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wr_valid: got %b want 0", i2c_wr_valid); end
      n_checks++; if (i2c_wr_addr !== 8'h00) begin n_fail++; $display("FAIL rst_wr_addr: got %h want 00", i2c_wr_addr); end
      n_checks++; if (i2c_wr_data !== 8'h00) begin n_fail++; $display("FAIL rst_wr_data: got %h want 00", i2c_wr_data); end
      n_checks++; if (dut.r_ptr !== 4'd0)    begin n_fail++; $display("FAIL rst_ptr: got %0d want 0", dut.r_ptr); end
      rst = 1'b0;
      wait_clk(4);
   endtask

   task automatic test_write_burst();
      logic a0, a1, a2, a3;
      int   w0;
      w0 = wr_cnt;
      bus_start();
      send_byte(8'h3C, a0);
      n_checks++; if (addressed !== 1'b1) begin n_fail++; $display("FAIL wb_addressed: got %b want 1", addressed); end
      n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL wb_busy: got %b want 1", busy); end
      send_byte(8'h03, a1);
      send_byte(8'hA5, a2);
      send_byte(8'h5A, a3);
      bus_stop();
      n_checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_fail++; $display("FAIL wb_acks: got %b want 0000", {a0, a1, a2, a3}); end
      n_checks++; if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL wb_pulses: got %0d want 2", wr_cnt - w0); end
      n_checks++; if ({log_addr[w0], log_data[w0]} !== 16'h03A5) begin n_fail++; $display("FAIL wb_first: got %h/%h want 03/a5", log_addr[w0], log_data[w0]); end
      n_checks++; if ({log_addr[w0+1], log_data[w0+1]} !== 16'h045A) begin n_fail++; $display("FAIL wb_second: got %h/%h want 04/5a", log_addr[w0+1], log_data[w0+1]); end
      n_checks++; if (dut.r_regs[3] !== 8'hA5) begin n_fail++; $display("FAIL wb_reg3: got %h want a5", dut.r_regs[3]); end
      n_checks++; if (dut.r_ptr !== 4'd5)      begin n_fail++; $display("FAIL wb_ptr: got %0d want 5", dut.r_ptr); end
      n_checks++; if (busy !== 1'b0)           begin n_fail++; $display("FAIL wb_busy_end: got %b want 0", busy); end
      n_checks++; if (addressed !== 1'b0)      begin n_fail++; $display("FAIL wb_addr_end: got %b want 0", addressed); end
   endtask

   task automatic test_read_wrap();
      logic       a;
      logic [7:0] d0, d1, d2;
      host_write(8'h0F, 8'h11);
      host_write(8'h00, 8'h22);
      host_write(8'h01, 8'h33);
      bus_start();
      send_byte(8'h3C, a);
      send_byte(8'h0F, a);
      bus_start();
      send_byte(8'h3D, a);
      n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack: got %b want 0", a); end
      recv_byte(1'b0, d0);
      recv_byte(1'b0, d1);
      recv_byte(1'b1, d2);
      wait_clk(2);
      n_checks++; if (d0 !== 8'h11) begin n_fail++; $display("FAIL rd_byte0: got %h want 11", d0); end
      n_checks++; if (d1 !== 8'h22) begin n_fail++; $display("FAIL rd_byte1: got %h want 22", d1); end
      n_checks++; if (d2 !== 8'h33) begin n_fail++; $display("FAIL rd_byte2: got %h want 33", d2); end
      n_checks++; if (dut.r_ptr !== 4'd2)   begin n_fail++; $display("FAIL rd_ptr: got %0d want 2", dut.r_ptr); end
      n_checks++; if (sda_t !== 1'b1)       begin n_fail++; $display("FAIL rd_release: got %b want 1", sda_t); end
      n_checks++; if (addressed !== 1'b0)   begin n_fail++; $display("FAIL rd_addressed: got %b want 0", addressed); end
      bus_stop();
   endtask

   task automatic test_wrong_addr();
      logic a0, a1, a2;
      int   w0, dr0;
      w0  = wr_cnt;
      dr0 = drive_cnt;
      bus_start();
      send_byte(8'h3A, a0);
      n_checks++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL wa_addressed: got %b want 0", addressed); end
      send_byte(8'h02, a1);
      send_byte(8'h55, a2);
      bus_stop();
      n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL wa_nacks: got %b want 111", {a0, a1, a2}); end
      n_checks++; if (drive_cnt !== dr0) begin n_fail++; $display("FAIL wa_drive: got %0d drive cycles want 0", drive_cnt - dr0); end
      n_checks++; if (wr_cnt !== w0)     begin n_fail++; $display("FAIL wa_pulses: got %0d want 0", wr_cnt - w0); end
      n_checks++; if (dut.r_ptr !== 4'd2) begin n_fail++; $display("FAIL wa_ptr: got %0d want 2", dut.r_ptr); end
   endtask

   task automatic test_stop_mid_byte();
      logic a, r;
      int   w0;
      host_write(8'h07, 8'hC3);
      w0 = wr_cnt;
      bus_start();
      send_byte(8'h3C, a);
      send_byte(8'h07, a);
      bus_bit(1'b1, r); bus_bit(1'b0, r); bus_bit(1'b1, r); bus_bit(1'b0, r);
      bus_stop();
      n_checks++; if (wr_cnt !== w0)            begin n_fail++; $display("FAIL sm_pulses: got %0d want 0", wr_cnt - w0); end
      n_checks++; if (dut.r_regs[7] !== 8'hC3)  begin n_fail++; $display("FAIL sm_reg7: got %h want c3", dut.r_regs[7]); end
      n_checks++; if (4'(dut.r_state) !== 4'd0) begin n_fail++; $display("FAIL sm_state: got %0d want 0 (idle)", dut.r_state); end
      n_checks++; if (busy !== 1'b0)            begin n_fail++; $display("FAIL sm_busy: got %b want 0", busy); end
      n_checks++; if (dut.r_ptr !== 4'd7)       begin n_fail++; $display("FAIL sm_ptr: got %0d want 7", dut.r_ptr); end
   endtask

   task automatic test_conflict();
      logic a, ah;
      bus_start();
      send_byte(8'h3C, a);
      send_byte(8'h04, a);
      send_byte_host(8'h99, 8'h04, 8'h77, ah);
      bus_stop();
      n_checks++; if (ah !== 1'b0)              begin n_fail++; $display("FAIL cf_ack: got %b want 0", ah); end
      n_checks++; if (dut.r_regs[4] !== 8'h99)  begin n_fail++; $display("FAIL cf_same_idx: got %h want 99", dut.r_regs[4]); end
      bus_start();
      send_byte(8'h3C, a);
      send_byte(8'h04, a);
      send_byte_host(8'h98, 8'h05, 8'h66, ah);
      bus_stop();
      n_checks++; if (dut.r_regs[4] !== 8'h98)  begin n_fail++; $display("FAIL cf_bus_reg4: got %h want 98", dut.r_regs[4]); end
      n_checks++; if (dut.r_regs[5] !== 8'h66)  begin n_fail++; $display("FAIL cf_host_reg5: got %h want 66", dut.r_regs[5]); end
   endtask

   task automatic test_reset_mid_read();
      logic a, r0, r1, r2;
      int   nz, w0;
      host_write(8'h00, 8'h22);
      bus_start();
      send_byte(8'h3C, a);
      send_byte(8'h00, a);
      bus_start();
      send_byte(8'h3D, a);
      bus_bit(1'b1, r0); bus_bit(1'b1, r1); bus_bit(1'b1, r2);
      wait_clk(HT);
      n_checks++; if ({r0, r1, r2} !== 3'b001) begin n_fail++; $display("FAIL rr_bits: got %b want 001", {r0, r1, r2}); end
      n_checks++; if (sda_t !== 1'b0) begin n_fail++; $display("FAIL rr_driving: got %b want 0", sda_t); end
      rst = 1'b1;
      wait_clk(1);
      n_checks++; if (sda_t !== 1'b1) begin n_fail++; $display("FAIL rr_release: got %b want 1", sda_t); end
      nz = 0;
      for (int i = 0; i < 16; i++) if (dut.r_regs[i] !== 8'h00) nz++;
      n_checks++; if (nz !== 0)        begin n_fail++; $display("FAIL rr_regs_clear: got %0d nonzero want 0", nz); end
      n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rr_busy: got %b want 0", busy); end
      rst = 1'b0;
      wait_clk(T);
      bus_stop();
      w0 = wr_cnt;
      bus_start();
      send_byte(8'h3C, a);
      n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL rr_next_ack: got %b want 0", a); end
      send_byte(8'h02, a);
      send_byte(8'h44, a);
      bus_stop();
      n_checks++; if (dut.r_regs[2] !== 8'h44) begin n_fail++; $display("FAIL rr_next_write: got %h want 44", dut.r_regs[2]); end
      n_checks++; if (wr_cnt - w0 !== 1)       begin n_fail++; $display("FAIL rr_next_pulse: got %0d want 1", wr_cnt - w0); end
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_read_wrap();
      test_wrong_addr();
      test_stop_mid_byte();
      test_conflict();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
